// File: rtl/ring_shift_bank.sv
// ring_shift_bank
//
// Bank of DEPTH stages, WIDTH bits each. A stage can take in a new word at
// either end of the bank, or the whole bank can rotate in either direction.
// The block counts how many stages hold valid data and tracks the rotation
// offset relative to the last load.
//
// Optional feature: define RING_TAP_EN to add the tap_sel input and the
// registered tap output, which reads a single stage.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; clears all state
//   shift    in   step enable, one operation per cycle while high
//   mode     in   00 shift-in fwd, 01 rotate fwd, 10 rotate rev, 11 shift-in rev
//   x        in   word shifted in (WIDTH)
//   tap_sel  in   stage index for tap (PW, RING_TAP_EN only)
//   y        out  all stages, stage i at y[i*WIDTH +: WIDTH]
//   fill     out  count of valid stages, saturates at DEPTH
//   full     out  fill == DEPTH
//   pos      out  rotation offset 0..DEPTH-1, cleared by any shift-in
//   wrap     out  one-cycle pulse when a rotate carries pos across 0
//   tap      out  stage[tap_sel] from the previous cycle (RING_TAP_EN only)

module ring_shift_bank #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 10,
    localparam int PW    = $clog2(DEPTH),
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shift,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       x,
`ifdef RING_TAP_EN
    input  logic [PW-1:0]          tap_sel,
    output logic [WIDTH-1:0]       tap,
`endif
    output logic [DEPTH*WIDTH-1:0] y,
    output logic [FW-1:0]          fill,
    output logic                   full,
    output logic [PW-1:0]          pos,
    output logic                   wrap
);

    typedef enum logic [1:0] {
        MODE_SHIFT_FWD = 2'b00,
        MODE_ROT_FWD   = 2'b01,
        MODE_ROT_REV   = 2'b10,
        MODE_SHIFT_REV = 2'b11
    } mode_e;

    localparam logic [PW-1:0] POS_LAST  = PW'(DEPTH - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

    mode_e            op;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [FW-1:0]    fill_d;
    logic [PW-1:0]    pos_d;
    logic             wrap_d;

    assign op = mode_e'(mode);

    // Next-state selection. Every operation reads only the registered
    // contents, so a mode change on any cycle acts on the current bank.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would infer a latch.
        stage_d = stage_q;
        fill_d  = fill;
        pos_d   = pos;
        wrap_d  = 1'b0;
        if (shift) begin
            unique case (op)
                MODE_SHIFT_FWD: begin
                    stage_d[0] = x;
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                    fill_d = (fill == FILL_FULL) ? fill : fill + FW'(1);
                    pos_d  = '0;
                end
                MODE_SHIFT_REV: begin
                    stage_d[DEPTH-1] = x;
                    for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
                    fill_d = (fill == FILL_FULL) ? fill : fill + FW'(1);
                    pos_d  = '0;
                end
                MODE_ROT_FWD: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                    // pos is a modulo-DEPTH counter; DEPTH need not be a power of 2.
                    pos_d  = (pos == POS_LAST) ? '0 : pos + PW'(1);
                    wrap_d = (pos == POS_LAST);
                end
                MODE_ROT_REV: begin
                    stage_d[DEPTH-1] = stage_q[0];
                    for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
                    pos_d  = (pos == '0) ? POS_LAST : pos - PW'(1);
                    wrap_d = (pos == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the stage array is cleared here, unlike typical storage,
            // because the bank is a visible output and must read all zero
            // right after reset.
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            fill <= '0;
            full <= 1'b0;
            pos  <= '0;
            wrap <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            stage_q <= stage_d;
            fill    <= fill_d;
            full    <= (fill_d == FILL_FULL);
            pos     <= pos_d;
            wrap    <= wrap_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_y
        assign y[g*WIDTH +: WIDTH] = stage_q[g];
    end

`ifdef RING_TAP_EN
    // Tap samples the pre-edge bank, so it trails any simultaneous shift by
    // one cycle. Out-of-range selects read as zero.
    logic tap_in_range;
    assign tap_in_range = (int'(tap_sel) < DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            tap <= '0;
        end else begin
            tap <= tap_in_range ? stage_q[tap_sel] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_ring_shift_bank.sv
// Self-checking bench for ring_shift_bank (default 32x10). A queue-based
// reference model predicts every output; a compare process checks it on
// each falling edge, and directed sequences pin the model with literals.

module tb_ring_shift_bank;

    localparam int WIDTH = 32;
    localparam int DEPTH = 10;
    localparam int PW    = $clog2(DEPTH);
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int CW    = DEPTH * WIDTH;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   shift;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       x;
    logic [PW-1:0]          tap_sel;
    logic [DEPTH*WIDTH-1:0] y;
    logic [FW-1:0]          fill;
    logic                   full;
    logic [PW-1:0]          pos;
    logic                   wrap;
`ifdef RING_TAP_EN
    logic [WIDTH-1:0]       tap;
`endif

    ring_shift_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .shift  (shift),
        .mode   (mode),
        .x      (x),
`ifdef RING_TAP_EN
        .tap_sel(tap_sel),
        .tap    (tap),
`endif
        .y      (y),
        .fill   (fill),
        .full   (full),
        .pos    (pos),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    // Reference model: bank as a queue, index 0 = stage0.
    logic [WIDTH-1:0] mq[$];
    int               m_fill;
    int               m_pos;
    bit               m_wrap;
    logic [WIDTH-1:0] m_tap;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [WIDTH-1:0] stage(input int i);
        return y[i*WIDTH +: WIDTH];
    endfunction

    task automatic model_update(input bit r, input bit s, input logic [1:0] md,
                                input logic [WIDTH-1:0] xv, input int ts);
        logic [WIDTH-1:0] t;
        m_tap  = (ts < DEPTH) ? mq[ts] : '0;
        m_wrap = 1'b0;
        if (r) begin
            foreach (mq[i]) mq[i] = '0;
            m_fill = 0;
            m_pos  = 0;
            m_tap  = '0;
        end else if (s) begin
            case (md)
                2'b00: begin
                    mq.push_front(xv); t = mq.pop_back();
                    m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
                    m_pos  = 0;
                end
                2'b11: begin
                    mq.push_back(xv); t = mq.pop_front();
                    m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
                    m_pos  = 0;
                end
                2'b01: begin
                    t = mq.pop_back(); mq.push_front(t);
                    m_wrap = (m_pos == DEPTH - 1);
                    m_pos  = (m_pos + 1) % DEPTH;
                end
                default: begin
                    t = mq.pop_front(); mq.push_back(t);
                    m_wrap = (m_pos == 0);
                    m_pos  = (m_pos + DEPTH - 1) % DEPTH;
                end
            endcase
        end
    endtask

    // One clock of stimulus: inputs settle, edge, model advances, then step
    // away from the edge before the next inputs change.
    task automatic step(input bit r, input bit s, input logic [1:0] md,
                        input logic [WIDTH-1:0] xv, input int ts);
        reset   = r;
        shift   = s;
        mode    = md;
        x       = xv;
        tap_sel = PW'(ts);
        @(posedge clk);
        model_update(r, s, md, xv, ts);
        #1;
    endtask

    always @(negedge clk) begin
        logic [CW-1:0] ey;
        if (chk_en) begin
            for (int i = 0; i < DEPTH; i++) ey[i*WIDTH +: WIDTH] = mq[i];
            check("y", y, ey);
            check("fill", fill, m_fill);
            check("full", full, m_fill == DEPTH);
            check("pos", pos, m_pos);
            check("wrap", wrap, m_wrap);
`ifdef RING_TAP_EN
            check("tap", tap, m_tap);
`endif
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mq.push_back('0);
        m_fill = 0; m_pos = 0; m_wrap = 0; m_tap = '0;

        step(1, 0, 2'b00, '0, 0);
        step(1, 1, 2'b01, 32'hFFFF_FFFF, 0);
        chk_en = 1'b1;
        check("reset_y", y, '0);
        check("reset_fill", fill, 0);
        check("reset_pos", pos, 0);

        // Fill forward with 1..12.
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 2'b00, WIDTH'(i), 0);
            check("fill_lit", fill, (i < 10) ? i : 10);
            check("full_lit", full, i >= 10);
        end
        for (int i = 0; i < DEPTH; i++) check("fill_stage_lit", stage(i), 12 - i);

        // Ten forward rotates: pos 1..9,0, single wrap on the last.
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 2'b01, '0, 0);
            check("rot_pos_lit", pos, i % 10);
            check("rot_wrap_lit", wrap, i == 10);
        end
        check("rot_restore0_lit", stage(0), 12);
        check("rot_restore9_lit", stage(9), 3);

        // Reverse from pos 0 then forward back.
        step(0, 1, 2'b10, '0, 0);
        check("rev_stage9_lit", stage(9), 12);
        check("rev_stage0_lit", stage(0), 11);
        check("rev_pos_lit", pos, 9);
        check("rev_wrap_lit", wrap, 1);
        step(0, 1, 2'b01, '0, 0);
        check("fwd_back_stage0_lit", stage(0), 12);
        check("fwd_back_pos_lit", pos, 0);
        check("fwd_back_wrap_lit", wrap, 1);

        // Rotate once (pos 1), then shift in reverse: pos clears, no wrap.
        step(0, 1, 2'b01, '0, 0);
        check("pre_rev_pos_lit", pos, 1);
        step(0, 1, 2'b11, 32'hA5A5_A5A5, 0);
        check("srev_stage9_lit", stage(9), 32'hA5A5_A5A5);
        check("srev_stage0_lit", stage(0), 12);
        check("srev_fill_lit", fill, 10);
        check("srev_pos_lit", pos, 0);
        check("srev_wrap_lit", wrap, 0);

        // Reset in the middle of a rotate run, then idle cycles.
        repeat (3) step(0, 1, 2'b01, '0, 0);
        step(1, 1, 2'b01, '0, 0);
        check("midrst_y_lit", y, '0);
        check("midrst_fill_lit", fill, 0);
        check("midrst_pos_lit", pos, 0);
        check("midrst_wrap_lit", wrap, 0);
        repeat (2) step(0, 0, 2'b01, 32'h1234, 0);
        check("hold_y_lit", y, '0);
        step(0, 1, 2'b00, 32'd7, 0);
        check("post_rst_stage0_lit", stage(0), 7);
        check("post_rst_stage1_lit", stage(1), 0);
        check("post_rst_fill_lit", fill, 1);

`ifdef RING_TAP_EN
        // Bank is [7,0,0,...]; after 101..103 stage3 holds 7.
        for (int i = 101; i <= 103; i++) step(0, 1, 2'b00, WIDTH'(i), 3);
        step(0, 1, 2'b00, 32'd104, 3);
        check("tap3_a_lit", tap, 7);
        step(0, 1, 2'b00, 32'd105, 3);
        check("tap3_b_lit", tap, 101);
        step(0, 0, 2'b00, '0, 10);
        check("tap_oor_lit", tap, 0);
`endif

        // Randomised operation mix with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 11));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ring_shift_bank.md
# ring_shift_bank

Parametrised ring/shift register bank: DEPTH stages of WIDTH-bit words that can shift a new word in from either end or rotate in either direction. It tracks how many stages hold valid data and where the ring sits relative to its load position. It is the generalised successor of the fixed 10×32 ring counter and is fed from the Nbit enable counter or any word source. All stage contents appear on a flat output bus for downstream tap logic.

## Interface
- WIDTH, 32, bits per stage word (≥1)
- DEPTH, 10, number of stages (≥2)
- PW (localparam), clog2(DEPTH), width of `pos`; fill width is clog2(DEPTH+1)
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high; one clock, synchronous active-high reset
- shift  input  1  step enable; one operation per cycle while high
- mode  input  2  00 shift-in fwd, 01 rotate fwd, 10 rotate rev, 11 shift-in rev
- x  input  WIDTH  word shifted in
- y  output  DEPTH*WIDTH  stage i at y[i*WIDTH +: WIDTH]
- fill  output  clog2(DEPTH+1)  count of valid stages
- full  output  1  fill == DEPTH
- pos  output  PW  rotation offset, 0..DEPTH-1
- wrap  output  1  one-cycle pulse on pos wrap
- tap_sel  input  PW  stage index (only with RING_TAP_EN)
- tap  output  WIDTH  selected stage word (only with RING_TAP_EN)

## Operation
- reset=1 at a clock edge: all stages 0, fill 0, full 0, pos 0, wrap 0, tap 0. Reset overrides shift and mode.
- shift=0: hold all state; wrap 0.
- Mode 00, shift-in forward: stage0←x, stage i←stage i-1, old stage DEPTH-1 discarded. fill increments and saturates at DEPTH. pos←0.
- Mode 11, shift-in reverse: stage DEPTH-1←x, stage i←stage i+1, old stage0 discarded. fill saturates at DEPTH. pos←0.
- Mode 01, rotate forward: stage0←stage DEPTH-1, stage i←stage i-1. pos←pos+1 mod DEPTH. fill unchanged.
- Mode 10, rotate reverse: stage DEPTH-1←stage0, stage i←stage i+1. pos←pos-1 mod DEPTH. fill unchanged.
- Rotation moves all DEPTH stages regardless of fill; invalid stages hold 0 or stale data and rotate along.
- wrap=1 for the cycle after a rotate that takes pos from DEPTH-1→0 (fwd) or 0→DEPTH-1 (rev); otherwise 0. A shift-in never asserts wrap, even when pos was nonzero.
- mode may change on any cycle; each cycle acts on the current registered contents.

## Timing
- All outputs are registered. An operation sampled at edge n is visible on y, fill, full, pos and wrap after edge n.
- Throughput: one operation per cycle, no stalls.
- DEPTH consecutive forward rotates return y to its original value and pos to 0; wrap pulses exactly once, on the DEPTH-th rotate.
- Forward rotate followed by reverse rotate restores y and pos; wrap pulses on neither step unless pos crossed the 0 boundary.
- Reset asserted mid-sequence clears everything at that edge. The first operation after reset deasserts acts on the all-zero bank.

## Configuration
- RING_TAP_EN defined: adds the tap_sel input and the registered tap output.
  - tap ← stage[tap_sel] sampled from the pre-edge contents, so it has 1-cycle latency and reflects stage values before any simultaneous shift.
  - tap_sel ≥ DEPTH → tap 0.
  - tap updates every cycle independent of shift; reset clears it.
- RING_TAP_EN undefined: no tap_sel or tap ports and no tap register. All other behaviour is identical.

## Test plan
- Defaults (32×10), reset, then 12 cycles mode 00 with x=1..12 → y stage0..9 = 12,11,…,3; fill 1..10 then stays 10; full from cycle 10.
- After the fill above, 10 cycles mode 01 → pos 1..9,0; wrap high only after the 10th step; y restored to 12,11,…,3.
- Mode 10 from pos 0 with stage0=12 → stage9=12, pos=9, wrap pulse; then mode 01 → original contents, pos 0, wrap pulse.
- Mode 11 with x=0xA5A5A5A5 on a full bank → stage9=0xA5A5A5A5, old stage0 dropped, pos←0, fill stays 10.
- Reset asserted during a rotate run with shift=1 → next cycle y all 0, fill 0, pos 0, wrap 0; shift=0 cycles hold state.
- RING_TAP_EN, tap_sel=3 while shifting in mode 00 → tap equals the prior cycle's stage3; tap_sel=10 → tap 0.
